// File: rtl/sopc_counter_pwm_out.sv
// Avalon-MM PWM output slave: double-buffered PERIOD/DUTY, free-running counter,
// registered PWM output, sticky period-done flag with level interrupt.
module sopc_counter_pwm_out #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned RESET_PERIOD = 999,
  parameter int unsigned RESET_DUTY   = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port,
  output logic        irq
);

  localparam logic [1:0] ADDR_CONTROL = 2'd0;
  localparam logic [1:0] ADDR_PERIOD  = 2'd1;
  localparam logic [1:0] ADDR_DUTY    = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam logic [WIDTH-1:0] PERIOD_RST = WIDTH'(RESET_PERIOD);
  localparam logic [WIDTH-1:0] DUTY_RST   = WIDTH'(RESET_DUTY);

  logic             enable_q, enable_d;
  logic             invert_q, invert_d;
  logic             irq_en_q, irq_en_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] per_p_q, per_p_d;
  logic [WIDTH-1:0] duty_p_q, duty_p_d;
  logic [WIDTH-1:0] per_a_q, per_a_d;
  logic [WIDTH-1:0] duty_a_q, duty_a_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]      readdata_d;
  logic             out_port_d;
  logic             irq_d;

  logic             wr_en;
  logic             wrap;
  logic             pwm;
  logic             reload;

  // Upper writedata bits beyond the register width are intentionally dropped.
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:WIDTH];

  // Next-state logic for all registers.
  always_comb begin
    enable_d   = enable_q;
    invert_d   = invert_q;
    irq_en_d   = irq_en_q;
    done_d     = done_q;
    per_p_d    = per_p_q;
    duty_p_d   = duty_p_q;
    per_a_d    = per_a_q;
    duty_a_d   = duty_a_q;
    cnt_d      = cnt_q;
    readdata_d = 32'd0;

    wr_en  = chipselect & ~write_n;
    wrap   = enable_q & (cnt_q == per_a_q);
    pwm    = enable_q & (cnt_q < duty_a_q);
    reload = ~enable_q | wrap;

    if (wr_en) begin
      case (address)
        ADDR_CONTROL: {irq_en_d, invert_d, enable_d} = writedata[2:0];
        ADDR_PERIOD:  per_p_d  = writedata[WIDTH-1:0];
        ADDR_DUTY:    duty_p_d = writedata[WIDTH-1:0];
        default:      done_d   = 1'b0;
      endcase
    end

    // A wrap in the same cycle as a STATUS write keeps done set.
    if (wrap) begin
      done_d = 1'b1;
    end

    // Active copies take the pending values seen before this edge's write.
    if (reload) begin
      per_a_d  = per_p_q;
      duty_a_d = duty_p_q;
    end

    cnt_d = reload ? '0 : cnt_q + WIDTH'(1);

    case (address)
      ADDR_CONTROL: readdata_d = 32'({irq_en_q, invert_q, enable_q});
      ADDR_PERIOD:  readdata_d = 32'(per_p_q);
      ADDR_DUTY:    readdata_d = 32'(duty_p_q);
      ADDR_STATUS:  readdata_d = 32'({enable_q, done_q});
      default:      readdata_d = 32'd0;
    endcase

    out_port_d = pwm ^ invert_q;
    irq_d      = done_d & irq_en_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q <= 1'b0;
      invert_q <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      per_p_q  <= PERIOD_RST;
      duty_p_q <= DUTY_RST;
      per_a_q  <= PERIOD_RST;
      duty_a_q <= DUTY_RST;
      cnt_q    <= '0;
      readdata <= 32'd0;
      out_port <= 1'b0;
      irq      <= 1'b0;
    end else begin
      enable_q <= enable_d;
      invert_q <= invert_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      per_p_q  <= per_p_d;
      duty_p_q <= duty_p_d;
      per_a_q  <= per_a_d;
      duty_a_q <= duty_a_d;
      cnt_q    <= cnt_d;
      readdata <= readdata_d;
      out_port <= out_port_d;
      irq      <= irq_d;
    end
  end

endmodule

// File: tb/tb_sopc_counter_pwm_out.sv
// Directed bench for sopc_counter_pwm_out; expectations queue up when stimulus
// is driven and are popped against DUT outputs on the falling edge.
module tb_sopc_counter_pwm_out;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        out_port;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  sopc_counter_pwm_out #(
    .WIDTH(16), .RESET_PERIOD(999), .RESET_DUTY(0)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0d, no expectation queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Called at a falling edge; the write lands on the following rising edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] v, input string tag);
    address = a;
    push(tag, v);
    step();
    pop_check(readdata);
  endtask

  initial begin
    // 1: reset values and register readback
    @(negedge clk);
    push("rst_readdata", 32'd0); pop_check(readdata);
    push("rst_out", 32'd0);      pop_check(32'(out_port));
    push("rst_irq", 32'd0);      pop_check(32'(irq));
    @(negedge clk);
    reset_n = 1'b1;
    rd(2'd0, 32'd0,   "rd_control");
    rd(2'd1, 32'd999, "rd_period");
    rd(2'd2, 32'd0,   "rd_duty");
    rd(2'd3, 32'd0,   "rd_status");
    push("idle_out", 32'd0); pop_check(32'(out_port));
    push("idle_irq", 32'd0); pop_check(32'(irq));

    // 2: period 10, duty 3
    wr(2'd1, 32'd9);
    wr(2'd2, 32'd3);
    wr(2'd0, 32'd1);
    address = 2'd3;
    for (int k = 1; k <= 25; k++) begin
      push($sformatf("p2_out k=%0d", k), 32'(((k - 1) % 10) < 3));
      if (k == 10) push("p2_status_before_wrap", 32'd2);
      if (k == 11) push("p2_status_after_wrap", 32'd3);
      step();
      pop_check(32'(out_port));
      if (k == 10 || k == 11) pop_check(readdata);
    end
    wr(2'd0, 32'd0);

    // 3: DUTY=7 written at cnt=2 takes effect at the next period
    wr(2'd0, 32'd1);
    for (int k = 1; k <= 30; k++) begin
      int d;
      d = (k <= 10) ? 3 : 7;
      push($sformatf("p3_out k=%0d", k), 32'(((k - 1) % 10) < d));
      if (k == 3) wr(2'd2, 32'd7);
      else step();
      pop_check(32'(out_port));
    end
    rd(2'd2, 32'd7, "p3_duty_pending");
    wr(2'd0, 32'd0);

    // 4a: duty 0 -> always low
    wr(2'd2, 32'd0);
    wr(2'd0, 32'd1);
    for (int k = 1; k <= 12; k++) begin
      push($sformatf("p4_duty0 k=%0d", k), 32'd0);
      step();
      pop_check(32'(out_port));
    end
    wr(2'd0, 32'd0);
    // 4b: duty beyond period -> always high
    wr(2'd2, 32'd12);
    wr(2'd0, 32'd1);
    for (int k = 1; k <= 12; k++) begin
      push($sformatf("p4_duty12 k=%0d", k), 32'd1);
      step();
      pop_check(32'(out_port));
    end
    wr(2'd0, 32'd0);
    // 4c: period 0 -> single-cycle periods, done on every edge
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd1);
    wr(2'd0, 32'd1);
    for (int k = 1; k <= 6; k++) begin
      push($sformatf("p4_per0 k=%0d", k), 32'd1);
      step();
      pop_check(32'(out_port));
    end
    wr(2'd3, 32'd0);
    rd(2'd3, 32'd3, "p4_per0_done_kept");
    wr(2'd0, 32'd0);
    // 4d: invert
    wr(2'd1, 32'd9);
    wr(2'd2, 32'd3);
    wr(2'd0, 32'd2);
    push("p4_inv_idle", 32'd1); step(); pop_check(32'(out_port));
    wr(2'd0, 32'd3);
    for (int k = 1; k <= 20; k++) begin
      push($sformatf("p4_inv k=%0d", k), 32'(!(((k - 1) % 10) < 3)));
      step();
      pop_check(32'(out_port));
    end
    wr(2'd0, 32'd0);

    // 5: interrupt, STATUS write on wrap and mid-period
    wr(2'd3, 32'd0);
    push("p5_irq_clear", 32'd0); pop_check(32'(irq));
    wr(2'd0, 32'd5);
    for (int k = 1; k <= 32; k++) begin
      push($sformatf("p5_irq k=%0d", k), 32'((k >= 10) && !(k >= 25 && k < 30)));
      if (k == 20 || k == 25) wr(2'd3, 32'd0);
      else step();
      pop_check(32'(irq));
    end

    // 6: asynchronous reset mid-period
    wr(2'd0, 32'd0);
    wr(2'd0, 32'd7);
    address = 2'd1;
    for (int k = 1; k <= 5; k++) step();
    push("p6_pre_out", 32'd1);  pop_check(32'(out_port));
    push("p6_pre_irq", 32'd1);  pop_check(32'(irq));
    push("p6_pre_rd", 32'd9);   pop_check(readdata);
    #2 reset_n = 1'b0;
    #1;
    push("p6_async_out", 32'd0); pop_check(32'(out_port));
    push("p6_async_irq", 32'd0); pop_check(32'(irq));
    push("p6_async_rd", 32'd0);  pop_check(readdata);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rd(2'd0, 32'd0,   "p6_control");
    rd(2'd1, 32'd999, "p6_period");
    push("p6_out_idle", 32'd0); pop_check(32'(out_port));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
